rp_decouple_seq: RTL

//  Sequences decoupling and recoupling of the reconfigurable partition (RP) across all irq_shim

---
 rtl/rp_decouple_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rp_decouple_seq.sv
// rtl/rp_decouple_seq.sv - decouple/recouple sequencer for the reconfigurable partition
// Drives shim decouple controls, drains host-pending IRQs, and holds the RP in reset while isolated.
module rp_decouple_seq #(
  parameter int NUM_SHIMS    = 4,
  parameter int IRQ_NUM      = 16,
  parameter int DRAIN_CYCLES = 1024,
  parameter int RST_CYCLES   = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_decouple,
  output logic [NUM_SHIMS-1:0] shim_decouple_control,
  input  logic [NUM_SHIMS-1:0] shim_decouple_status,
  input  logic [IRQ_NUM-1:0]   irq_pend,
  output logic                 rp_resetn,
  output logic                 decoupled,
  output logic                 busy,
  output logic                 drain_timeout
);

  localparam int MAX_CNT = (DRAIN_CYCLES > RST_CYCLES) ? DRAIN_CYCLES : RST_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_COUPLED   = 3'd0,
    S_ASSERT    = 3'd1,
    S_DRAIN     = 3'd2,
    S_DECOUPLED = 3'd3,
    S_RELEASE   = 3'd4,
    S_DEASSERT  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 timeout_q, timeout_d;
  logic [NUM_SHIMS-1:0] ctrl_q, ctrl_d;
  logic                 rstn_q, rstn_d;
  logic                 dec_q, dec_d;
  logic                 busy_q, busy_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_DECOUPLED;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      ctrl_q    <= '1;
      rstn_q    <= 1'b0;
      dec_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      ctrl_q    <= ctrl_d;
      rstn_q    <= rstn_d;
      dec_q     <= dec_d;
      busy_q    <= busy_d;
    end
  end

  // Requests are only sampled in the two stable states, so a started sequence always completes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_COUPLED: if (req_decouple) state_d = S_ASSERT;
      S_ASSERT: begin
        if (&shim_decouple_status) begin
          state_d   = S_DRAIN;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (irq_pend == '0) begin
          state_d = S_DECOUPLED;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d   = S_DECOUPLED;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECOUPLED: begin
        if (!req_decouple) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end
      end
      S_RELEASE: begin
        if (cnt_q == RST_LAST) state_d = S_DEASSERT;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      S_DEASSERT: if (shim_decouple_status == '0) state_d = S_COUPLED;
      default: state_d = S_DECOUPLED;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    ctrl_d = '1;
    rstn_d = 1'b1;
    dec_d  = 1'b0;
    busy_d = 1'b0;
    unique case (state_d)
      S_COUPLED:   ctrl_d = '0;
      S_ASSERT:    busy_d = 1'b1;
      S_DRAIN:     busy_d = 1'b1;
      S_DECOUPLED: begin
        rstn_d = 1'b0;
        dec_d  = 1'b1;
      end
      S_RELEASE:   busy_d = 1'b1;
      S_DEASSERT: begin
        ctrl_d = '0;
        busy_d = 1'b1;
      end
      default: begin
        rstn_d = 1'b0;
        dec_d  = 1'b1;
      end
    endcase
  end

  assign shim_decouple_control = ctrl_q;
  assign rp_resetn             = rstn_q;
  assign decoupled             = dec_q;
  assign busy                  = busy_q;
  assign drain_timeout         = timeout_q;

endmodule
